vx_ipdom_stack_dual: RTL

- Per-warp immediate-post-dominator (IPDOM) reconvergence stack for the warp scheduler's split/join path.
- Generalises the single-port IPDOM stack:
  - warp count is a parameter;
  - push and pop are independent valid/ready ports, so they can fire in the same cycle for different warps;
  - each entry holds a pair of payloads (else-path and reconvergence);
  - per-warp depth is exported to the scheduler.
- Payload data lives in a 1W1R dual-port RAM; the per-entry phase flags live in flops.

---
 rtl/vx_ipdom_stack_dual.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vx_ipdom_stack_dual.sv
// Per-warp IPDOM reconvergence stack with independent push/pop ports and a 1W1R payload RAM.
// Optional statistics (high-water mark, rejected-push counter) are enabled by VX_IPDOM_STACK_STATS_EN.
module vx_ipdom_stack_dual #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int NUM_WARPS = 4,
    parameter int OUT_REG   = 0,
    localparam int NWW  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNTW = ((DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_valid,
    input  logic [NWW-1:0]            push_wid,
    input  logic [WIDTH-1:0]          push_rcv,
    input  logic [WIDTH-1:0]          push_els,
    output logic                      push_ready,
    input  logic                      pop_valid,
    input  logic [NWW-1:0]            pop_wid,
    output logic                      pop_ready,
    output logic                      rsp_valid,
    output logic [NWW-1:0]            rsp_wid,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_idx,
    output logic [NUM_WARPS*CNTW-1:0] depth,
    output logic [NUM_WARPS-1:0]      empty,
    output logic [NUM_WARPS-1:0]      full,
    output logic [NUM_WARPS*CNTW-1:0] stat_hwm,
    output logic [15:0]               stat_ovf
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = SW + NWW;

    logic [CNTW-1:0]  cnt_all [NUM_WARPS];
    logic [DEPTH-1:0] ph_all  [NUM_WARPS];

    logic [NWW-1:0] push_w, pop_w;
    logic [SW-1:0]  push_slot, pop_slot;
    logic           push_fire, pop_fire, pop_ph;

    // With a single warp the id inputs carry no information.
    assign push_w = (NUM_WARPS == 1) ? '0 : push_wid;
    assign pop_w  = (NUM_WARPS == 1) ? '0 : pop_wid;

    assign push_ready = ~full[push_w];
    assign pop_ready  = ~empty[pop_w] & ~(push_valid & (push_w == pop_w));
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop_valid & pop_ready;

    assign push_slot = SW'(cnt_all[push_w]);
    assign pop_slot  = SW'(cnt_all[pop_w] - CNTW'(1));
    assign pop_ph    = ph_all[pop_w][pop_slot];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [CNTW-1:0]  cnt_reg;
            logic [DEPTH-1:0] ph_reg;
            logic             push_hit, pop_hit;

            assign push_hit = push_fire & (push_w == NWW'(gi));
            assign pop_hit  = pop_fire & (pop_w == NWW'(gi));

            // A same-warp push blocks the pop, so the two hits are exclusive.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                    ph_reg  <= '0;
                end else if (push_hit) begin
                    cnt_reg           <= cnt_reg + CNTW'(1);
                    ph_reg[push_slot] <= 1'b0;
                end else if (pop_hit) begin
                    if (pop_ph)
                        cnt_reg <= cnt_reg - CNTW'(1);
                    else
                        ph_reg[pop_slot] <= 1'b1;
                end
            end

            assign cnt_all[gi]             = cnt_reg;
            assign ph_all[gi]              = ph_reg;
            assign empty[gi]               = (cnt_reg == '0);
            assign full[gi]                = (cnt_reg == CNTW'(DEPTH));
            assign depth[gi*CNTW +: CNTW]  = cnt_reg;
        end
    endgenerate

    // Payload RAM, address {slot, wid}; each word is {rcv, els}.
    logic [2*WIDTH-1:0] ram_mem [0:(1<<AW)-1];
    logic [2*WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (push_fire)
            ram_mem[{push_slot, push_w}] <= {push_rcv, push_els};
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data_reg <= '0;
        else if (pop_fire)
            rd_data_reg <= ram_mem[{pop_slot, pop_w}];
    end

    logic           s1_valid_reg, s1_idx_reg;
    logic [NWW-1:0] s1_wid_reg;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_wid_reg   <= '0;
            s1_idx_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= pop_fire;
            if (pop_fire) begin
                s1_wid_reg <= pop_w;
                s1_idx_reg <= pop_ph;
            end
        end
    end

    // Phase flag at fire time selects which half of the word is returned.
    assign s1_data = s1_idx_reg ? rd_data_reg[2*WIDTH-1:WIDTH] : rd_data_reg[WIDTH-1:0];

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             out_valid_reg, out_idx_reg;
            logic [NWW-1:0]   out_wid_reg;
            logic [WIDTH-1:0] out_data_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid_reg <= 1'b0;
                    out_wid_reg   <= '0;
                    out_data_reg  <= '0;
                    out_idx_reg   <= 1'b0;
                end else begin
                    out_valid_reg <= s1_valid_reg;
                    out_wid_reg   <= s1_wid_reg;
                    out_data_reg  <= s1_data;
                    out_idx_reg   <= s1_idx_reg;
                end
            end

            assign rsp_valid = out_valid_reg;
            assign rsp_wid   = out_wid_reg;
            assign rsp_data  = out_data_reg;
            assign rsp_idx   = out_idx_reg;
        end else begin : g_out_comb
            assign rsp_valid = s1_valid_reg;
            assign rsp_wid   = s1_wid_reg;
            assign rsp_data  = s1_data;
            assign rsp_idx   = s1_idx_reg;
        end
    endgenerate

`ifdef VX_IPDOM_STACK_STATS_EN
    logic [15:0] ovf_reg;

    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_hwm
            logic [CNTW-1:0] hwm_reg;

            // Tracks the settled count, so it lags a push by one edge.
            always_ff @(posedge clk) begin
                if (reset)
                    hwm_reg <= '0;
                else if (cnt_all[gi] > hwm_reg)
                    hwm_reg <= cnt_all[gi];
            end

            assign stat_hwm[gi*CNTW +: CNTW] = hwm_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            ovf_reg <= '0;
        else if (push_valid && !push_ready && (ovf_reg != 16'hFFFF))
            ovf_reg <= ovf_reg + 16'd1;
    end

    assign stat_ovf = ovf_reg;
`else
    assign stat_hwm = '0;
    assign stat_ovf = '0;
`endif

    a_push_not_full: assert property (@(posedge clk) disable iff (reset)
        push_fire |-> !full[push_w]);
    a_pop_not_empty: assert property (@(posedge clk) disable iff (reset)
        pop_fire |-> !empty[pop_w]);
    a_push_wid_range: assert property (@(posedge clk) disable iff (reset)
        push_valid |-> (32'(push_wid) < NUM_WARPS));
    a_pop_wid_range: assert property (@(posedge clk) disable iff (reset)
        pop_valid |-> (32'(pop_wid) < NUM_WARPS));

endmodule
